// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one external 16-bit asynchronous SRAM among four requesters
//   (sensor reader, A/D converter, match core, register/save path).
//
//   The arbiter grants requesters round-robin. A requester that holds its
//   lock bit keeps ownership across a burst. It also sequences the
//   WE_N/OE_N/DQ pins for every access. Only this block drives the SRAM pins.
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_req/i_we/i_lock    per-requester request, write enable and burst lock (bit k = requester k)
//   i_addr               4 x 20-bit addresses, requester k at [20k+19:20k]
//   i_wdata              4 x 16-bit write data, requester k at [16k+15:16k]
//   o_gnt                one-hot pulse in the first ACCESS cycle (request latched)
//   o_done               one-hot pulse in the first IDLE cycle after ACCESS
//   o_rdata              last read data; valid with o_done of a read, held otherwise
//   o_busy               high while an access is in progress
//   o_SRAM_*/io_SRAM_DQ  SRAM pins; CE_N/LB_N/UB_N are tied active
module sram_arbiter #(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [19:0] IDLE_ADDR     = 20'd12999
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_req,
  input  logic [3:0]  i_we,
  input  logic [3:0]  i_lock,
  input  logic [79:0] i_addr,
  input  logic [63:0] i_wdata,
  output logic [3:0]  o_gnt,
  output logic [3:0]  o_done,
  output logic [15:0] o_rdata,
  output logic        o_busy,
  output logic [19:0] o_SRAM_ADDR,
  inout  wire  [15:0] io_SRAM_DQ,
  output logic        o_SRAM_WE_N,
  output logic        o_SRAM_OE_N,
  output logic        o_SRAM_CE_N,
  output logic        o_SRAM_LB_N,
  output logic        o_SRAM_UB_N
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t      state_r, state_next_s;
  logic [3:0]  cnt_r, cnt_next_s;
  logic [1:0]  last_r, last_next_s;
  logic [1:0]  win_s;
  logic        we_lat_r, we_lat_next_s;
  logic [15:0] dq_out_r, dq_out_next_s;
  logic        dq_oe_r, dq_oe_next_s;
  logic [19:0] addr_r, addr_next_s;
  logic        we_n_r, we_n_next_s;
  logic        oe_n_r, oe_n_next_s;
  logic [3:0]  gnt_r, gnt_next_s;
  logic [3:0]  done_r, done_next_s;
  logic [15:0] rdata_r, rdata_next_s;
  logic        busy_r, busy_next_s;

  // One-hot decode of a requester index.
  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  // First requesting index found searching upward from (last+1) mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end else begin
        found   = found;
      end
    end
  endfunction

  // Winner selection: a locked owner re-wins only in its own o_done cycle.
  always_comb begin
    win_s = last_r;
    if (done_r[last_r] && i_lock[last_r] && i_req[last_r]) begin
      win_s = last_r;
    end else begin
      win_s = rr_pick(i_req, last_r);
    end
  end

  // Next-state and next-pin logic; pins are registered, so they describe the coming cycle.
  always_comb begin
    state_next_s  = state_r;
    cnt_next_s    = cnt_r;
    last_next_s   = last_r;
    we_lat_next_s = we_lat_r;
    dq_out_next_s = dq_out_r;
    dq_oe_next_s  = 1'b0;
    addr_next_s   = IDLE_ADDR;
    we_n_next_s   = 1'b1;
    oe_n_next_s   = 1'b0;
    gnt_next_s    = 4'b0000;
    done_next_s   = 4'b0000;
    rdata_next_s  = rdata_r;
    case (state_r)
      ST_IDLE: begin
        if (|i_req) begin
          state_next_s  = ST_ACCESS;
          cnt_next_s    = CNT_LOAD;
          last_next_s   = win_s;
          we_lat_next_s = i_we[win_s];
          dq_out_next_s = i_wdata[{win_s, 4'b0000} +: 16];
          addr_next_s   = i_addr[32'd20 * 32'(win_s) +: 20];
          gnt_next_s    = onehot(win_s);
          if (i_we[win_s]) begin
            // ACCESS_CYCLES >= 2, so the first cycle is never the hold cycle.
            we_n_next_s  = 1'b0;
            oe_n_next_s  = 1'b1;
            dq_oe_next_s = 1'b1;
          end else begin
            we_n_next_s  = 1'b1;
            oe_n_next_s  = 1'b0;
            dq_oe_next_s = 1'b0;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_r == 4'd0) begin
          // Final cycle: pins return to idle values, DQ is released with WE_N already high.
          state_next_s = ST_IDLE;
          done_next_s  = onehot(last_r);
          if (!we_lat_r) begin
            rdata_next_s = io_SRAM_DQ;
          end else begin
            rdata_next_s = rdata_r;
          end
        end else begin
          cnt_next_s  = cnt_r - 4'd1;
          addr_next_s = addr_r;
          if (we_lat_r) begin
            // WE_N rises for the last cycle so address and data are held past the strobe.
            we_n_next_s  = (cnt_r == 4'd1);
            oe_n_next_s  = 1'b1;
            dq_oe_next_s = 1'b1;
          end else begin
            we_n_next_s  = 1'b1;
            oe_n_next_s  = 1'b0;
            dq_oe_next_s = 1'b0;
          end
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
    busy_next_s = (state_next_s == ST_ACCESS);
  end

  // State, latched request and registered SRAM pins; reset aborts any access in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      last_r   <= 2'd3;
      we_lat_r <= 1'b0;
      dq_out_r <= 16'h0000;
      dq_oe_r  <= 1'b0;
      addr_r   <= IDLE_ADDR;
      we_n_r   <= 1'b1;
      oe_n_r   <= 1'b0;
      gnt_r    <= 4'b0000;
      done_r   <= 4'b0000;
      rdata_r  <= 16'h0000;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      cnt_r    <= cnt_next_s;
      last_r   <= last_next_s;
      we_lat_r <= we_lat_next_s;
      dq_out_r <= dq_out_next_s;
      dq_oe_r  <= dq_oe_next_s;
      addr_r   <= addr_next_s;
      we_n_r   <= we_n_next_s;
      oe_n_r   <= oe_n_next_s;
      gnt_r    <= gnt_next_s;
      done_r   <= done_next_s;
      rdata_r  <= rdata_next_s;
      busy_r   <= busy_next_s;
    end
  end

  assign io_SRAM_DQ  = dq_oe_r ? dq_out_r : 16'hzzzz;
  assign o_SRAM_ADDR = addr_r;
  assign o_SRAM_WE_N = we_n_r;
  assign o_SRAM_OE_N = oe_n_r;
  assign o_SRAM_CE_N = 1'b0;
  assign o_SRAM_LB_N = 1'b0;
  assign o_SRAM_UB_N = 1'b0;
  assign o_gnt       = gnt_r;
  assign o_done      = done_r;
  assign o_rdata     = rdata_r;
  assign o_busy      = busy_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Self-checking bench for sram_arbiter: directed table, hand sequences for
//   reset/withdrawal/lock, then random accesses against a reference model.
//   A small SRAM model covers addresses 12992..13023.
module tb_sram_arbiter;

  localparam int          AC        = 2;
  localparam logic [19:0] IDLE_ADDR = 20'd12999;
  localparam int          BASE      = 12992;

  logic        clk;
  logic        rst;
  logic [3:0]  req, we, lock;
  logic [79:0] addr;
  logic [63:0] wdata;
  logic [3:0]  gnt, done;
  logic [15:0] rdata;
  logic        busy;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_lb_n, sram_ub_n;

  logic [15:0] mem [32];
  logic [15:0] sram_rd;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [15:0] ref_mem [32];
  int          ref_last;
  logic        ref_done;
  logic [15:0] ref_rdata;

  sram_arbiter #(.ACCESS_CYCLES(AC), .IDLE_ADDR(IDLE_ADDR)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_lock(lock),
    .i_addr(addr), .i_wdata(wdata), .o_gnt(gnt), .o_done(done),
    .o_rdata(rdata), .o_busy(busy), .o_SRAM_ADDR(sram_addr),
    .io_SRAM_DQ(sram_dq), .o_SRAM_WE_N(sram_we_n), .o_SRAM_OE_N(sram_oe_n),
    .o_SRAM_CE_N(sram_ce_n), .o_SRAM_LB_N(sram_lb_n), .o_SRAM_UB_N(sram_ub_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: drives DQ while output-enabled and not writing.
  assign sram_rd = (sram_addr >= 20'd12992 && sram_addr < 20'd13024) ? mem[sram_addr[4:0]] : 16'h0000;
  assign sram_dq = (sram_oe_n == 1'b0 && sram_we_n == 1'b1) ? sram_rd : 16'hzzzz;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);
    mem[7] = 16'h0003;
    forever begin
      @(posedge clk);
      if (sram_we_n == 1'b0 && sram_addr >= 20'd12992 && sram_addr < 20'd13024)
        mem[sram_addr[4:0]] = sram_dq;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic reset_dut();
    rst = 1'b1; req = 4'b0000; we = 4'b0000; lock = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_last = 3; ref_done = 1'b0; ref_rdata = 16'h0000;
  endtask

  // Reference winner: locked owner in its done cycle, else first requester after last.
  function automatic int model_pick(input logic [3:0] rq, input logic [3:0] lk);
    if (ref_done && rq[ref_last] && lk[ref_last]) return ref_last;
    for (int k = 1; k <= 4; k++) if (rq[(ref_last + k) % 4]) return (ref_last + k) % 4;
    return -1;
  endfunction

  // Starts in an IDLE cycle, ends in the o_done cycle of the access.
  task automatic run_access(input logic [3:0] rq, input logic [3:0] w, input logic [3:0] lk,
                            input logic [79:0] ad, input logic [63:0] wd,
                            input int exp_win, input logic [15:0] exp_rd, input string tag);
    logic [19:0] a;
    logic [15:0] d;
    logic        wr;
    req = rq; we = w; lock = lk; addr = ad; wdata = wd;
    a  = ad[exp_win*20 +: 20];
    d  = wd[exp_win*16 +: 16];
    wr = w[exp_win];
    @(posedge clk); #1;
    chk({tag, ":gnt"}, 32'(gnt), 32'(4'b0001 << exp_win));
    ref_last = exp_win;
    for (int c = 1; c <= AC; c++) begin
      chk({tag, ":addr"}, 32'(sram_addr), 32'(a));
      chk({tag, ":busy"}, 32'(busy), 32'd1);
      chk({tag, ":done_in_access"}, 32'(done), 32'd0);
      if (wr) begin
        chk({tag, ":we_n_wr"}, 32'(sram_we_n), (c < AC) ? 32'd0 : 32'd1);
        chk({tag, ":oe_n_wr"}, 32'(sram_oe_n), 32'd1);
        chk({tag, ":dq_wr"}, 32'(sram_dq), 32'(d));
      end else begin
        chk({tag, ":we_n_rd"}, 32'(sram_we_n), 32'd1);
        chk({tag, ":oe_n_rd"}, 32'(sram_oe_n), 32'd0);
      end
      @(posedge clk); #1;
    end
    chk({tag, ":done"}, 32'(done), 32'(4'b0001 << exp_win));
    chk({tag, ":gnt_in_done"}, 32'(gnt), 32'd0);
    chk({tag, ":busy_idle"}, 32'(busy), 32'd0);
    chk({tag, ":rdata"}, 32'(rdata), 32'(exp_rd));
    chk({tag, ":idle_addr"}, 32'(sram_addr), 32'(IDLE_ADDR));
    if (wr) ref_mem[a - 20'(BASE)] = d;
    ref_rdata = exp_rd;
    ref_done  = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [19:0] addr;
    logic [15:0] wdata;
    int          exp_win;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int          win;
    logic [3:0]  rq, w, lk;
    logic [79:0] ad;
    logic [63:0] wd;
    logic [15:0] erd;

    for (int i = 0; i < 32; i++) ref_mem[i] = 16'h1000 + 16'(i);
    ref_mem[7] = 16'h0003;

    // Round-robin from reset, re-aim last=1, then 3/1 alternation, then write/read.
    vecs[0]  = '{4'b1111, 4'b0000, 20'd13001, 16'h0000, 0, 16'h1009};
    vecs[1]  = '{4'b1111, 4'b0000, 20'd13001, 16'h0000, 1, 16'h1009};
    vecs[2]  = '{4'b1111, 4'b0000, 20'd13001, 16'h0000, 2, 16'h1009};
    vecs[3]  = '{4'b1111, 4'b0000, 20'd13001, 16'h0000, 3, 16'h1009};
    vecs[4]  = '{4'b1111, 4'b0000, 20'd13001, 16'h0000, 0, 16'h1009};
    vecs[5]  = '{4'b0010, 4'b0000, 20'd13001, 16'h0000, 1, 16'h1009};
    vecs[6]  = '{4'b1010, 4'b0000, 20'd13001, 16'h0000, 3, 16'h1009};
    vecs[7]  = '{4'b1010, 4'b0000, 20'd13001, 16'h0000, 1, 16'h1009};
    vecs[8]  = '{4'b1010, 4'b0000, 20'd13001, 16'h0000, 3, 16'h1009};
    vecs[9]  = '{4'b0100, 4'b0100, 20'd13000, 16'hA5C3, 2, 16'h1009};
    vecs[10] = '{4'b0010, 4'b0000, 20'd13000, 16'h0000, 1, 16'hA5C3};

    addr = '0; wdata = '0;
    rst = 1'b1; req = 4'b0000; we = 4'b0000; lock = 4'b0000;
    @(posedge clk); @(posedge clk); #1;
    chk("rst:gnt", 32'(gnt), 32'd0);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:rdata", 32'(rdata), 32'd0);
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:we_n", 32'(sram_we_n), 32'd1);
    chk("rst:oe_n", 32'(sram_oe_n), 32'd0);
    chk("rst:addr", 32'(sram_addr), 32'(IDLE_ADDR));
    chk("rst:tied", 32'({sram_ce_n, sram_lb_n, sram_ub_n}), 32'd0);
    rst = 1'b0;
    ref_last = 3; ref_done = 1'b0; ref_rdata = 16'h0000;

    run_access(4'b0001, 4'b0000, 4'b0000, {4{20'd12999}}, '0, 0, 16'h0003, "single");

    reset_dut();
    for (int i = 0; i < 11; i++)
      run_access(vecs[i].req, vecs[i].we, 4'b0000, {4{vecs[i].addr}}, {4{vecs[i].wdata}},
                 vecs[i].exp_win, vecs[i].exp_rdata, $sformatf("vec%0d", i));

    // Withdrawal: requester 3 pulses i_req during an access and drops it.
    req = 4'b0001; we = 4'b0000; lock = 4'b0000; addr = {4{20'd12999}};
    @(posedge clk); #1;
    chk("wd:gnt0", 32'(gnt), 32'd1);
    req = 4'b1000;
    @(posedge clk); #1;
    req = 4'b0000;
    @(posedge clk); #1;
    chk("wd:done0", 32'(done), 32'd1);
    chk("wd:rdata", 32'(rdata), 32'(ref_mem[7]));
    ref_last = 0; ref_rdata = ref_mem[7];
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("wd:no_gnt", 32'(gnt), 32'd0);
      chk("wd:busy", 32'(busy), 32'd0);
    end
    ref_done = 1'b0;

    // Reset in the second ACCESS cycle of a write.
    reset_dut();
    req = 4'b0100; we = 4'b0100; addr = {4{20'd13002}}; wdata = {4{16'h1234}};
    @(posedge clk); #1;
    chk("rw:gnt", 32'(gnt), 32'h4);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rw:we_n", 32'(sram_we_n), 32'd1);
    chk("rw:oe_n", 32'(sram_oe_n), 32'd0);
    chk("rw:done", 32'(done), 32'd0);
    chk("rw:gnt0", 32'(gnt), 32'd0);
    chk("rw:busy", 32'(busy), 32'd0);
    chk("rw:addr", 32'(sram_addr), 32'(IDLE_ADDR));
    chk("rw:rdata", 32'(rdata), 32'd0);
    rst = 1'b0;
    ref_last = 3; ref_done = 1'b0; ref_rdata = 16'h0000;
    ref_mem[10] = 16'h1234;  // the WE_N strobe reached the SRAM before the abort
    run_access(4'b0101, 4'b0000, 4'b0000, {4{20'd12999}}, '0, 0, ref_mem[7], "rw_after");

    // Lock burst: ten grants to 0 while 1 waits, then 1 once the lock drops.
    reset_dut();
    for (int i = 0; i < 10; i++)
      run_access(4'b0011, 4'b0000, 4'b0001, {20'd0, 20'd0, 20'd13004, 20'd13003}, '0,
                 0, ref_mem[11], $sformatf("lock%0d", i));
    run_access(4'b0011, 4'b0000, 4'b0000, {20'd0, 20'd0, 20'd13004, 20'd13003}, '0,
               1, ref_mem[12], "unlock");

    // Random accesses against the model.
    for (int n = 0; n < 300; n++) begin
      rq = 4'($urandom_range(0, 15));
      w  = 4'($urandom_range(0, 15));
      lk = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) begin
        ad[k*20 +: 20] = 20'(BASE + $urandom_range(0, 31));
        wd[k*16 +: 16] = 16'($urandom);
      end
      if (rq == 4'b0000) begin
        req = 4'b0000;
        @(posedge clk); #1;
        chk("rnd:idle_gnt", 32'(gnt), 32'd0);
        chk("rnd:idle_busy", 32'(busy), 32'd0);
        ref_done = 1'b0;
      end else begin
        win = model_pick(rq, lk);
        erd = w[win] ? ref_rdata : ref_mem[ad[win*20 +: 20] - 20'(BASE)];
        run_access(rq, w, lk, ad, wd, win, erd, "rnd");
      end
    end

    req = 4'b0000;
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Single-port SRAM arbiter and access sequencer for the fingerprint pipeline. It shares the one external 16-bit asynchronous SRAM among four requesters: the sensor reader, the A/D converter, the match core and the register/save path. Only this block drives the SRAM pins. It grants requesters round-robin, with optional burst locking, and generates the WE_N/OE_N/DQ timing for each access. It replaces the per-state address/data muxing in the top level.

## Interface
- ACCESS_CYCLES, 2, cycles per SRAM access; legal range 2..15.
- IDLE_ADDR, 20'd12999, address driven while idle (the DB-size word, so the top level can snoop it).
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  4  per-requester access request; bit k belongs to requester k.
- i_we  in  4  per-requester write enable; 1 = write, 0 = read.
- i_lock  in  4  per-requester burst lock.
- i_addr  in  80  per-requester address; requester k uses [20k+19:20k].
- i_wdata  in  64  per-requester write data; requester k uses [16k+15:16k].
- o_gnt  out  4  one-hot, one-cycle pulse; the request is latched.
- o_done  out  4  one-hot, one-cycle pulse; the access is complete.
- o_rdata  out  16  read data; valid with o_done for a read.
- o_busy  out  1  high while not IDLE.
- o_SRAM_ADDR  out  20  SRAM address.
- io_SRAM_DQ  inout  16  SRAM data bus.
- o_SRAM_WE_N, o_SRAM_OE_N  out  1  each; write and output enables, active-low.
- o_SRAM_CE_N, o_SRAM_LB_N, o_SRAM_UB_N  out  1  each; tied 0.

## Operation
- **States:** IDLE and ACCESS.
- **IDLE:**
  - o_SRAM_ADDR = IDLE_ADDR, OE_N = 0, WE_N = 1, DQ = z.
  - If any i_req bit is high, select a winner.
  - Latch the winner's addr, we and wdata.
  - Load the wait counter with ACCESS_CYCLES-1 and go to ACCESS.
- **Winner selection:**
  - Locked owner first: if the previous winner p had i_lock[p]=1 and i_req[p]=1 in its o_done cycle, p wins again.
  - Otherwise round-robin: search from requester (last+1) mod 4 upward.
  - Pointer `last` updates to the winner on every grant.
- **ACCESS:**
  - o_SRAM_ADDR = latched address throughout.
  - Read: OE_N = 0, WE_N = 1, DQ = z. On the final ACCESS cycle (counter = 0), capture io_SRAM_DQ into o_rdata.
  - Write: OE_N = 1 and DQ driven with the latched data on all ACCESS cycles. WE_N = 0 on every ACCESS cycle except the final one. The final cycle is data/address hold with WE_N = 1.
  - Counter decrements each cycle. At 0 the state returns to IDLE.
- **Outputs on transitions:**
  - o_gnt[winner] is high during the first ACCESS cycle.
  - o_done[winner] is high during the first IDLE cycle after ACCESS.
  - o_rdata is updated only by reads and holds between reads. A write leaves it unchanged.
- **Requester rules:**
  - Hold i_req, i_we, i_addr and i_wdata stable until o_gnt.
  - After o_gnt, inputs may change. Holding i_req high requests a further access.
  - Dropping i_req before o_gnt withdraws the request. No grant is issued if no other bit is high.
- **Reset:**
  - Values: state IDLE, last = 3 (requester 0 wins first), lock ownership cleared.
  - o_gnt = 0, o_done = 0, o_rdata = 0, o_busy = 0, WE_N = 1, OE_N = 0, DQ = z, addr = IDLE_ADDR.
  - Reset asserted mid-ACCESS aborts the access: outputs reach reset values at that edge and no o_done is issued.

## Timing
- Request seen in IDLE cycle T:
  - o_gnt at T+1.
  - Read data captured at the edge ending T+ACCESS_CYCLES.
  - o_done and o_rdata valid at T+ACCESS_CYCLES+1.
- Back-to-back throughput: one access per ACCESS_CYCLES+1 cycles. The o_done cycle is also the arbitration cycle for the next access.
- DQ is released (z) in the same cycle WE_N returns high after the hold cycle. No cycle drives DQ with OE_N = 0.
- o_gnt and o_done are never high in the same cycle. At most one bit of each is high.

## Test plan
- **Single read:** reset; SRAM model holds 16'h0003 at 12999; i_req=4'b0001, i_addr[19:0]=12999, ACCESS_CYCLES=2 → o_gnt=0001 at T+1, o_done=0001 at T+3, o_rdata=16'h0003. WE_N stays 1 throughout.
- **Round-robin:** i_req=4'b1111 held continuously after reset → grant order 0,1,2,3,0. Then assert only bits 3 and 1 with last=1 → order 3,1,3.
- **Write then read:** requester 2 writes 16'hA5C3 to 20'd13000; check WE_N low for exactly ACCESS_CYCLES-1 cycles, DQ driven, OE_N=1. Requester 1 then reads 13000 → o_rdata=16'hA5C3.
- **Lock:** requester 0 bursts 10 reads with i_lock[0]=1 while i_req[1]=1 → ten consecutive grants to 0, then requester 1 is granted when i_lock[0] drops.
- **Reset mid-write:** i_rst high on the second ACCESS cycle → next cycle WE_N=1, DQ=z, o_done=0, addr=12999. The first post-reset grant goes to requester 0.
- **Withdrawal:** a requester raises i_req for one cycle while the arbiter is busy and drops it → no o_gnt to that requester.
